// File: rtl/mbist_access_ctrl_if.sv
// System-side access port of the MBIST access controller.
// The requester drives the master modport; the controller implements the slave side.
interface mbist_access_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 4
);
  logic          sys_req;
  logic          sys_we;
  logic [AW-1:0] sys_addr;
  logic [DW-1:0] sys_wdata;
  logic          sys_gnt;
  logic [DW-1:0] sys_rdata;

  modport master (
    output sys_req, sys_we, sys_addr, sys_wdata,
    input  sys_gnt, sys_rdata
  );

  modport slave (
    input  sys_req, sys_we, sys_addr, sys_wdata,
    output sys_gnt, sys_rdata
  );
endinterface

// File: rtl/mbist_access_ctrl.sv
// Shares a single-port test SRAM between the system port and a March C engine.
// It drains system traffic, runs the engine, compacts read data into a MISR and reports pass/fail/timeout.
module mbist_access_ctrl #(
  parameter int            AW         = 8,
  parameter int            DW         = 4,
  parameter logic [15:0]   TO_CYCLES  = 16'd8192,
  parameter logic [DW-1:0] MISR_POLY  = 4'b0011,
  parameter logic [DW-1:0] GOLDEN_SIG = 4'b0000
) (
  input  logic                clk,
  input  logic                rst_n,
  mbist_access_ctrl_if.slave  sys,
  input  logic                bist_start,
  input  logic                bist_clr,
  output logic                bist_busy,
  output logic                bist_done,
  output logic                bist_pass,
  output logic                bist_timeout,
  output logic [DW-1:0]       bist_sig,
  output logic [15:0]         bist_cycles,
  output logic                eng_en,
  input  logic [AW-1:0]       eng_addr,
  input  logic [DW-1:0]       eng_wdata,
  input  logic                eng_wen,
  input  logic                eng_done,
  output logic [DW-1:0]       eng_rdata,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic                mem_we,
  input  logic [DW-1:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    RUN,
    CHECK,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] sig_q, sig_d;
  logic [15:0]   cycles_q, cycles_d;
  logic          pass_q, pass_d;
  logic          timeout_q, timeout_d;
  logic          run_first_q, run_first_d;
  logic          sys_gnt;
  logic [DW-1:0] misr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sig_q       <= '0;
      cycles_q    <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      run_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sig_q       <= sig_d;
      cycles_q    <= cycles_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      run_first_q <= run_first_d;
    end
  end

  assign misr_next = ({sig_q[DW-2:0], 1'b0} ^ (sig_q[DW-1] ? MISR_POLY : '0)) ^ mem_rdata;

  always_comb begin
    state_d     = state_q;
    sig_d       = sig_q;
    cycles_d    = cycles_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    run_first_d = (state_q == DRAIN);
    sys_gnt     = 1'b0;
    mem_addr    = sys.sys_addr;
    mem_wdata   = sys.sys_wdata;
    mem_we      = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bist_start) begin
          state_d   = DRAIN;
          sig_d     = '0;
          cycles_d  = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
        end else begin
          sys_gnt = sys.sys_req;
          mem_we  = sys.sys_req & sys.sys_we & sys_gnt;
          if ((state_q == DONE) && bist_clr) begin
            state_d   = IDLE;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
          end
        end
      end

      DRAIN: begin
        state_d = RUN;
      end

      RUN: begin
        mem_addr  = eng_addr;
        mem_wdata = eng_wdata;
        mem_we    = eng_wen;
        // The first RUN cycle still sees read data from the drained system port.
        if (!run_first_q && !eng_wen) begin
          sig_d = misr_next;
        end
        // The exit cycle is not counted, so a timeout leaves the count at TO_CYCLES-1.
        if (eng_done) begin
          state_d = CHECK;
        end else if (cycles_q == (TO_CYCLES - 16'd1)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else if (cycles_q != 16'hFFFF) begin
          cycles_d = cycles_q + 16'd1;
        end
      end

      CHECK: begin
        pass_d    = (sig_q == GOLDEN_SIG);
        timeout_d = 1'b0;
        state_d   = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sys.sys_gnt   = sys_gnt;
  assign sys.sys_rdata = mem_rdata;
  assign eng_rdata     = mem_rdata;
  assign eng_en        = (state_q == RUN) && run_first_q;
  assign bist_busy     = (state_q == DRAIN) || (state_q == RUN) || (state_q == CHECK);
  assign bist_done     = (state_q == DONE);
  assign bist_pass     = pass_q;
  assign bist_timeout  = timeout_q;
  assign bist_sig      = sig_q;
  assign bist_cycles   = cycles_q;

endmodule

// File: tb/tb_mbist_access_ctrl.sv
// Directed bench for mbist_access_ctrl: SRAM model with optional stuck-at-0 fault and a scripted engine.
// A vector table covers system access and a clean run; hand sequences cover fault, timeout, restart and reset.
module tb_mbist_access_ctrl;
  localparam int          AW = 8;
  localparam int          DW = 4;
  localparam logic [15:0] TO = 16'd8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          bist_start = 1'b0;
  logic          bist_clr = 1'b0;
  logic          bist_busy, bist_done, bist_pass, bist_timeout;
  logic [DW-1:0] bist_sig;
  logic [15:0]   bist_cycles;
  logic          eng_en;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] eng_wdata;
  logic          eng_wen;
  logic          eng_done;
  logic [DW-1:0] eng_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  int n_checks = 0;
  int n_fails  = 0;

  mbist_access_ctrl_if #(.AW(AW), .DW(DW)) sys_if ();

  mbist_access_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sys          (sys_if),
    .bist_start   (bist_start),
    .bist_clr     (bist_clr),
    .bist_busy    (bist_busy),
    .bist_done    (bist_done),
    .bist_pass    (bist_pass),
    .bist_timeout (bist_timeout),
    .bist_sig     (bist_sig),
    .bist_cycles  (bist_cycles),
    .eng_en       (eng_en),
    .eng_addr     (eng_addr),
    .eng_wdata    (eng_wdata),
    .eng_wen      (eng_wen),
    .eng_done     (eng_done),
    .eng_rdata    (eng_rdata),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  // SRAM model: synchronous read of the old contents, optional stuck-at-0 on bit 2 of 8'h3A
  logic [DW-1:0] sram [0:255];
  logic [DW-1:0] sram_rdata = '0;
  logic          clear_mem = 1'b1;
  logic          fault_on = 1'b0;

  always @(posedge clk) begin
    sram_rdata <= sram[mem_addr] & ((fault_on && mem_addr == 8'h3A) ? 4'hB : 4'hF);
    if (clear_mem) begin
      for (int i = 0; i < 256; i++) sram[i] <= '0;
    end else if (mem_we) begin
      sram[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = sram_rdata;

  // Engine model: after the eng_en pulse it plays a fixed five-op script, the last op carrying done
  typedef struct packed {
    logic [7:0] addr;
    logic [3:0] wdata;
    logic       wen;
    logic       done;
  } eng_op_t;

  eng_op_t    script [0:4];
  logic       eng_enable = 1'b1;
  logic       eng_active = 1'b0;
  logic [2:0] eng_idx = 3'd0;
  eng_op_t    eng_cur;

  always @(posedge clk) begin
    if (eng_en && eng_enable) begin
      eng_active <= 1'b1;
      eng_idx    <= 3'd0;
    end else if (eng_active) begin
      if (eng_idx == 3'd4) eng_active <= 1'b0;
      eng_idx <= 3'(eng_idx + 3'd1);
    end
  end

  always_comb begin
    eng_cur = '0;
    if (eng_active && eng_idx < 3'd5) eng_cur = script[eng_idx];
  end

  assign eng_addr  = eng_cur.addr;
  assign eng_wdata = eng_cur.wdata;
  assign eng_wen   = eng_cur.wen;
  assign eng_done  = eng_cur.done;

  typedef struct {
    logic       rst_n;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [3:0] wdata;
    logic       start;
    logic       clr;
    logic       exp_gnt;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_pass;
    logic       exp_to;
    logic       exp_en;
    logic       chk_rd;
    logic [3:0] exp_rd;
  } vec_t;

  vec_t vecs [0:15];

  function automatic vec_t mk(input logic r, input logic q, input logic w, input logic [7:0] a,
                              input logic [3:0] d, input logic s, input logic c, input logic g,
                              input logic b, input logic dn, input logic p, input logic t,
                              input logic e, input logic cr, input logic [3:0] rd);
    vec_t v;
    v.rst_n = r; v.req = q; v.we = w; v.addr = a; v.wdata = d; v.start = s; v.clr = c;
    v.exp_gnt = g; v.exp_busy = b; v.exp_done = dn; v.exp_pass = p; v.exp_to = t;
    v.exp_en = e; v.chk_rd = cr; v.exp_rd = rd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst_n            = v.rst_n;
    sys_if.sys_req   = v.req;
    sys_if.sys_we    = v.we;
    sys_if.sys_addr  = v.addr;
    sys_if.sys_wdata = v.wdata;
    bist_start       = v.start;
    bist_clr         = v.clr;
  endtask

  task automatic waitDone(input int max_cycles, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      @(negedge clk);
      n++;
      if (bist_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int n;
    bit ok;
    bit found;

    script[0] = '{addr: 8'h3A, wdata: 4'h4, wen: 1'b1, done: 1'b0};
    script[1] = '{addr: 8'h3B, wdata: 4'h8, wen: 1'b1, done: 1'b0};
    script[2] = '{addr: 8'h3A, wdata: 4'h0, wen: 1'b0, done: 1'b0};
    script[3] = '{addr: 8'h3B, wdata: 4'h0, wen: 1'b0, done: 1'b0};
    script[4] = '{addr: 8'h00, wdata: 4'h0, wen: 1'b0, done: 1'b1};

    //              rst req we addr   wd    st clr  gnt bsy dn ps to en  chk rd
    vecs[0]  = mk(0, 1, 0, 8'h00, 4'h0, 0, 0,  1, 0, 0, 0, 0, 0,  0, 4'h0);
    vecs[1]  = mk(1, 1, 1, 8'h10, 4'h5, 0, 0,  1, 0, 0, 0, 0, 0,  0, 4'h0);
    vecs[2]  = mk(1, 1, 0, 8'h10, 4'h0, 0, 0,  1, 0, 0, 0, 0, 0,  0, 4'h0);
    vecs[3]  = mk(1, 0, 0, 8'h00, 4'h0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 4'h5);
    vecs[4]  = mk(1, 1, 0, 8'h10, 4'h0, 1, 0,  0, 0, 0, 0, 0, 0,  0, 4'h0);
    vecs[5]  = mk(1, 1, 0, 8'h10, 4'h0, 0, 0,  0, 1, 0, 0, 0, 0,  0, 4'h0);
    vecs[6]  = mk(1, 0, 0, 8'h00, 4'h0, 0, 0,  0, 1, 0, 0, 0, 1,  0, 4'h0);
    vecs[7]  = mk(1, 0, 0, 8'h00, 4'h0, 1, 0,  0, 1, 0, 0, 0, 0,  0, 4'h0);
    vecs[8]  = mk(1, 1, 1, 8'h3A, 4'hF, 0, 0,  0, 1, 0, 0, 0, 0,  0, 4'h0);
    vecs[9]  = mk(1, 0, 0, 8'h00, 4'h0, 0, 0,  0, 1, 0, 0, 0, 0,  0, 4'h0);
    vecs[10] = mk(1, 0, 0, 8'h00, 4'h0, 0, 0,  0, 1, 0, 0, 0, 0,  0, 4'h0);
    vecs[11] = mk(1, 0, 0, 8'h00, 4'h0, 0, 0,  0, 1, 0, 0, 0, 0,  0, 4'h0);
    vecs[12] = mk(1, 0, 0, 8'h00, 4'h0, 0, 0,  0, 1, 0, 0, 0, 0,  0, 4'h0);
    vecs[13] = mk(1, 1, 0, 8'h10, 4'h0, 0, 0,  1, 0, 1, 1, 0, 0,  0, 4'h0);
    vecs[14] = mk(1, 0, 0, 8'h00, 4'h0, 0, 1,  0, 0, 1, 1, 0, 0,  0, 4'h0);
    vecs[15] = mk(1, 0, 0, 8'h00, 4'h0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 4'h0);

    sys_if.sys_req   = 1'b0;
    sys_if.sys_we    = 1'b0;
    sys_if.sys_addr  = '0;
    sys_if.sys_wdata = '0;
    repeat (2) @(posedge clk);
    #1 clear_mem = 1'b0;

    $display("[TB] vector table: system access and clean BIST run");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d sys_gnt", i), 32'(sys_if.sys_gnt), 32'(vecs[i].exp_gnt));
      checkOutput($sformatf("v%0d bist_busy", i), 32'(bist_busy), 32'(vecs[i].exp_busy));
      checkOutput($sformatf("v%0d bist_done", i), 32'(bist_done), 32'(vecs[i].exp_done));
      checkOutput($sformatf("v%0d bist_pass", i), 32'(bist_pass), 32'(vecs[i].exp_pass));
      checkOutput($sformatf("v%0d bist_timeout", i), 32'(bist_timeout), 32'(vecs[i].exp_to));
      checkOutput($sformatf("v%0d eng_en", i), 32'(eng_en), 32'(vecs[i].exp_en));
      if (vecs[i].chk_rd) checkOutput($sformatf("v%0d sys_rdata", i), 32'(sys_if.sys_rdata), 32'(vecs[i].exp_rd));
      if (i == 0) begin
        checkOutput("reset bist_sig", 32'(bist_sig), 32'h0);
        checkOutput("reset bist_cycles", 32'(bist_cycles), 32'h0);
      end
    end
    checkOutput("clean bist_sig", 32'(bist_sig), 32'h0);

    $display("[TB] stuck-at-0 on bit 2 of 8'h3A");
    @(posedge clk); #1 clear_mem = 1'b1; fault_on = 1'b1;
    @(posedge clk); #1 clear_mem = 1'b0; bist_start = 1'b1;
    @(posedge clk); #1 bist_start = 1'b0;
    waitDone(40, n, ok);
    checkOutput("fault done reached", 32'(ok), 32'h1);
    checkOutput("fault bist_pass", 32'(bist_pass), 32'h0);
    checkOutput("fault bist_timeout", 32'(bist_timeout), 32'h0);
    checkOutput("fault bist_sig", 32'(bist_sig), 32'h8);
    @(posedge clk); #1 bist_clr = 1'b1;
    @(posedge clk); #1 bist_clr = 1'b0;
    @(negedge clk);
    checkOutput("clr bist_done", 32'(bist_done), 32'h0);
    checkOutput("clr bist_pass", 32'(bist_pass), 32'h0);
    checkOutput("clr keeps bist_sig", 32'(bist_sig), 32'h8);
    fault_on = 1'b0;

    $display("[TB] timeout run with a silent engine");
    eng_enable = 1'b0;
    @(posedge clk); #1 bist_start = 1'b1;
    @(posedge clk); #1 bist_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (eng_en) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("timeout eng_en seen", 32'(found), 32'h1);
    waitDone(int'(TO) + 20, n, ok);
    checkOutput("timeout done reached", 32'(ok), 32'h1);
    checkOutput("timeout run length", 32'(n), 32'(TO));
    checkOutput("timeout bist_timeout", 32'(bist_timeout), 32'h1);
    checkOutput("timeout bist_pass", 32'(bist_pass), 32'h0);
    checkOutput("timeout bist_cycles", 32'(bist_cycles), 32'(TO - 16'd1));

    $display("[TB] restart from DONE, start ignored in RUN, reset mid-run");
    @(posedge clk); #1 bist_start = 1'b1; bist_clr = 1'b1; sys_if.sys_req = 1'b1; sys_if.sys_we = 1'b0;
    @(negedge clk);
    checkOutput("restart sys_gnt", 32'(sys_if.sys_gnt), 32'h0);
    @(posedge clk); #1 bist_start = 1'b0; bist_clr = 1'b0;
    @(negedge clk);
    checkOutput("restart bist_busy", 32'(bist_busy), 32'h1);
    checkOutput("restart bist_done", 32'(bist_done), 32'h0);
    checkOutput("restart bist_timeout", 32'(bist_timeout), 32'h0);
    checkOutput("restart bist_cycles", 32'(bist_cycles), 32'h0);
    @(negedge clk);
    checkOutput("restart eng_en", 32'(eng_en), 32'h1);
    @(posedge clk); #1 bist_start = 1'b1;
    @(negedge clk);
    checkOutput("run start eng_en", 32'(eng_en), 32'h0);
    @(posedge clk); #1 bist_start = 1'b0;
    @(negedge clk);
    checkOutput("run start busy", 32'(bist_busy), 32'h1);
    @(negedge clk);
    checkOutput("run start no re-pulse", 32'(eng_en), 32'h0);
    checkOutput("run start busy 2", 32'(bist_busy), 32'h1);
    @(posedge clk); #1 rst_n = 1'b0;
    #2;
    checkOutput("midrun rst bist_busy", 32'(bist_busy), 32'h0);
    checkOutput("midrun rst bist_done", 32'(bist_done), 32'h0);
    checkOutput("midrun rst bist_timeout", 32'(bist_timeout), 32'h0);
    checkOutput("midrun rst bist_pass", 32'(bist_pass), 32'h0);
    checkOutput("midrun rst eng_en", 32'(eng_en), 32'h0);
    checkOutput("midrun rst sys_gnt", 32'(sys_if.sys_gnt), 32'h1);
    checkOutput("midrun rst bist_cycles", 32'(bist_cycles), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post rst sys_gnt req1", 32'(sys_if.sys_gnt), 32'h1);
    checkOutput("post rst bist_busy", 32'(bist_busy), 32'h0);
    @(posedge clk); #1 sys_if.sys_req = 1'b0;
    @(negedge clk);
    checkOutput("post rst sys_gnt req0", 32'(sys_if.sys_gnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
